// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu: multi-cycle multiply/divide unit for the MIPS execute stage.
//
// Implements mult, multu, div, divu, mthi and mtlo against the HI/LO register
// pair. Long operations (mult/multu/div/divu) latch their operands and op,
// hold busy high for a fixed number of cycles, write HI/LO on the final edge
// and pulse done in the following cycle. mthi/mtlo write in a single edge.
//
// Optional feature macro: MDU_DIV_EN
//   defined   -> div/divu supported
//   undefined -> divider not built; op 3/4 behave like op 0 (no operation)
//
// Parameters:
//   MULT_CYCLES  busy duration of mult/multu in cycles (>= 1)
//   DIV_CYCLES   busy duration of div/divu in cycles (>= 1)
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   start    request valid this cycle
//   op       0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   a        rs operand (dividend / multiplicand / mthi-mtlo source)
//   b        rt operand (divisor / multiplier)
//   busy     long operation in flight (registered, follows FSM state)
//   done     one-cycle pulse after HI/LO take a long-operation result
//   hi, lo   HI and LO registers
// ---------------------------------------------------------------------------
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
`endif

  // Counter is sized for the longer of the two latencies so one register
  // serves both operation classes.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_d, lo_d;
  logic          busy_d, done_d;

  // Products from the latched operands only, so a/b may change during RUN.
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

`ifdef MDU_DIV_EN
  // Signed division runs on magnitudes through one unsigned divider, then
  // fixes signs: quotient negative when signs differ (truncation toward
  // zero), remainder takes the dividend's sign. The magnitude of 0x80000000
  // is itself as an unsigned value, so the overflow case 0x80000000 / -1
  // naturally yields quotient 0x80000000 and remainder 0.
  logic        div_signed;
  logic [31:0] div_a_mag;
  logic [31:0] div_b_mag;
  logic [31:0] divisor;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  assign div_signed = (op_q == OP_DIV);
  assign div_a_mag  = (div_signed && a_q[31]) ? -a_q : a_q;
  assign div_b_mag  = (div_signed && b_q[31]) ? -b_q : b_q;
  // Divide-by-zero results are discarded; substituting 1 keeps the divider
  // output well defined.
  assign divisor    = (div_b_mag == 32'd0) ? 32'd1 : div_b_mag;
  assign uq         = div_a_mag / divisor;
  assign ur         = div_a_mag % divisor;
  assign div_quo    = (div_signed && (a_q[31] ^ b_q[31])) ? -uq : uq;
  assign div_rem    = (div_signed && a_q[31]) ? -ur : ur;
`endif

  // State, operand latches, counter and HI/LO registers. busy and done are
  // registered so they are glitch-free for the hazard unit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi      <= hi_d;
      lo      <= lo_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic. In IDLE a request is accepted; in RUN the counter
  // counts down and the final edge (count of 1) commits the result.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi;
    lo_d    = lo;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              count_d = CW'(MULT_CYCLES);
              state_d = RUN;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              count_d = CW'(DIV_CYCLES);
              state_d = RUN;
            end
`endif
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      RUN: begin
        if (count_q <= CW'(1)) begin
          state_d = IDLE;
          count_d = '0;
          done_d  = 1'b1;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              if (b_q != 32'd0) begin
                hi_d = div_rem;
                lo_d = div_quo;
              end
            end
`endif
            default: ;
          endcase
        end else begin
          count_d = count_q - CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu: self-checking bench for mdu.
//
// Directed and randomized operations are compared against a reference model
// built from plain 64-bit arithmetic. Div expectations follow MDU_DIV_EN.
// ---------------------------------------------------------------------------
module tb_mdu;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int TIMEOUT     = 100;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared;
  int mismatched;

  logic [31:0] model_hi;
  logic [31:0] model_lo;

  mdu #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, asserts, reports on failure.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: HI/LO effect of one accepted operation, expressed as
  // ordinary signed/unsigned 64-bit arithmetic.
  task automatic model_apply(input logic [2:0] m_op, input logic [31:0] m_a,
                             input logic [31:0] m_b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] res;
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    ua = {32'b0, m_a};
    ub = {32'b0, m_b};
    case (m_op)
      3'd1: begin
        res = 64'(sa * sb);
        model_hi = res[63:32];
        model_lo = res[31:0];
      end
      3'd2: begin
        res = ua * ub;
        model_hi = res[63:32];
        model_lo = res[31:0];
      end
      3'd3: if (DIV_EN && m_b != 32'd0) begin
        model_lo = 32'(sa / sb);
        model_hi = 32'(sa % sb);
      end
      3'd4: if (DIV_EN && m_b != 32'd0) begin
        model_lo = 32'(ua / ub);
        model_hi = 32'(ua % ub);
      end
      3'd5: model_hi = m_a;
      3'd6: model_lo = m_a;
      default: ;
    endcase
  endtask

  // Issues one request at a falling edge and checks the whole transaction.
  // Long operations: busy length, done pulse, HI/LO. Others: no busy/done and
  // HI/LO per model. Optionally fires an mtlo while busy, which must be
  // ignored. Entered and left on a falling edge.
  task automatic apply_stimulus(input string tag, input logic [2:0] s_op,
                                input logic [31:0] s_a, input logic [31:0] s_b,
                                input bit inject_mtlo);
    bit is_long;
    int n_exp;
    int cnt;
    is_long = (s_op == 3'd1) || (s_op == 3'd2) ||
              (DIV_EN && (s_op == 3'd3 || s_op == 3'd4));
    n_exp   = (s_op == 3'd1 || s_op == 3'd2) ? MULT_CYCLES : DIV_CYCLES;

    start = 1'b1;
    op    = s_op;
    a     = s_a;
    b     = s_b;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;

    if (is_long) begin
      cnt = 0;
      while (busy === 1'b1 && cnt < TIMEOUT) begin
        cnt++;
        if (inject_mtlo && cnt == 1) begin
          start = 1'b1;
          op    = 3'd6;
        end else begin
          start = 1'b0;
          op    = 3'd0;
        end
        a = $urandom;
        b = $urandom;
        @(negedge clk);
      end
      start = 1'b0;
      op    = 3'd0;
      check_output({tag, "_busy_cycles"}, 32'(cnt), 32'(n_exp));
      check_output({tag, "_done"}, {31'b0, done}, 32'd1);
      model_apply(s_op, s_a, s_b);
      check_output({tag, "_hi"}, hi, model_hi);
      check_output({tag, "_lo"}, lo, model_lo);
      @(negedge clk);
      check_output({tag, "_done_clear"}, {31'b0, done}, 32'd0);
    end else begin
      check_output({tag, "_no_busy"}, {31'b0, busy}, 32'd0);
      check_output({tag, "_no_done"}, {31'b0, done}, 32'd0);
      model_apply(s_op, s_a, s_b);
      check_output({tag, "_hi"}, hi, model_hi);
      check_output({tag, "_lo"}, lo, model_lo);
    end
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    compared   = 0;
    mismatched = 0;
    model_hi   = '0;
    model_lo   = '0;
    reset_n    = 1'b0;
    start      = 1'b0;
    op         = 3'd0;
    a          = '0;
    b          = '0;

    repeat (3) @(negedge clk);
    check_output("reset_busy", {31'b0, busy}, 32'd0);
    check_output("reset_done", {31'b0, done}, 32'd0);
    check_output("reset_hi", hi, 32'd0);
    check_output("reset_lo", lo, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases with hand-computed constants alongside the model.
    apply_stimulus("mult_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check_output("mult_hi_const", hi, 32'hFFFF_FFFF);
    check_output("mult_lo_const", lo, 32'hFFFF_FFFA);

    apply_stimulus("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_output("multu_hi_const", hi, 32'hFFFF_FFFE);
    check_output("multu_lo_const", lo, 32'h0000_0001);

    apply_stimulus("div_neg7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    apply_stimulus("divu_7_2", 3'd4, 32'd7, 32'd2, 1'b0);
    if (DIV_EN) begin
      check_output("divu_lo_const", lo, 32'd3);
      check_output("divu_hi_const", hi, 32'd1);
    end

    apply_stimulus("mthi", 3'd5, 32'h1234_5678, 32'd0, 1'b0);
    apply_stimulus("div_by_zero", 3'd3, 32'hDEAD_BEEF, 32'd0, DIV_EN);
    check_output("div_by_zero_hi_kept", hi, 32'h1234_5678);

    apply_stimulus("div_overflow", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    apply_stimulus("divu_by_zero", 3'd4, 32'h0000_1234, 32'd0, 1'b0);
    apply_stimulus("op_none", 3'd0, 32'hCAFE_F00D, 32'd1, 1'b0);
    apply_stimulus("op_reserved", 3'd7, 32'hCAFE_F00D, 32'd1, 1'b0);
    apply_stimulus("mtlo", 3'd6, 32'h0BAD_CAFE, 32'd0, 1'b0);

    // Randomized operations; small divisors are favoured so zero and one
    // divisors come up regularly.
    for (int i = 0; i < 16; i++) begin
      r_op = 3'($urandom_range(1, 6));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      apply_stimulus("random", r_op, r_a, r_b, 1'b0);
    end

    // Abort a mult in its third RUN cycle with an asynchronous reset.
    start = 1'b1;
    op    = 3'd1;
    a     = 32'h7654_3210;
    b     = 32'h0000_0123;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check_output("abort_busy_before", {31'b0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_hi = '0;
    model_lo = '0;
    check_output("abort_busy", {31'b0, busy}, 32'd0);
    check_output("abort_done", {31'b0, done}, 32'd0);
    check_output("abort_hi", hi, model_hi);
    check_output("abort_lo", lo, model_lo);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    op    = 3'd6;
    a     = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    check_output("post_abort_mtlo", lo, 32'hA5A5_A5A5);
    check_output("post_abort_hi", hi, 32'd0);
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    repeat (MULT_CYCLES + 2) @(negedge clk);
    check_output("post_abort_no_done", {31'b0, done}, 32'd0);
    check_output("post_abort_lo_hold", lo, 32'hA5A5_A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
